// File: rtl/seq_ones_counter.sv
// Sequential population counter: counts the ones in a WIDTH-bit word,
// CHUNK bits per clock, under a start/busy/done handshake. An optional
// saturating accumulator sums counts across words.
//
// Handshake: start is only sampled in IDLE, and data_in and mode are captured
// on that same edge. busy stays high from the cycle after acceptance through
// the DONE cycle. done is a single-cycle pulse, and count/total are valid
// in that cycle. A start seen while busy is dropped and never queued.
module seq_ones_counter #(
  parameter  int WIDTH = 16,
  parameter  int CHUNK = 4,
  parameter  int ACC_W = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic [ACC_W-1:0] total,
  output logic             sat
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shift_q;
  logic [CW-1:0]      partial_q;
  logic [IDX_W-1:0]   idx_q;
  logic               mode_q;
  logic               busy_q;
  logic               done_q;
  logic [CW-1:0]      count_q;
  logic [ACC_W-1:0]   total_q;
  logic               sat_q;

  logic [CW-1:0]      chunk_ones;
  logic [CW-1:0]      sum_d;
  logic [ACC_W:0]     acc_sum_d;
  logic               last_chunk;

  // Ones in the low CHUNK bits of a word.
  function automatic logic [CW-1:0] popcnt(input logic [CHUNK-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Per-cycle arithmetic: chunk popcount, running sum, and the accumulator
  // sum, which carries one extra bit so an overflow shows up as the MSB.
  always_comb begin
    chunk_ones = popcnt(shift_q[CHUNK-1:0]);
    sum_d      = partial_q + chunk_ones;
    acc_sum_d  = {1'b0, total_q} + {{(ACC_W + 1 - CW){1'b0}}, sum_d};
    last_chunk = (idx_q == IDX_W'(N - 1));
  end

  // Control FSM together with all registered outputs. A clear in the same
  // cycle as a total update overrides it, because it is the last assignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      partial_q <= '0;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      total_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q   <= data_in;
            mode_q    <= mode;
            partial_q <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          partial_q <= sum_d;
          shift_q   <= shift_q >> CHUNK;
          idx_q     <= idx_q + IDX_W'(1);
          if (last_chunk) begin
            count_q <= sum_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
            if (mode_q) begin
              if (acc_sum_d[ACC_W]) begin
                total_q <= '1;
                sat_q   <= 1'b1;
              end else begin
                total_q <= acc_sum_d[ACC_W-1:0];
              end
            end else begin
              total_q <= ACC_W'(sum_d);
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
      if (clear) begin
        total_q <= '0;
        sat_q   <= 1'b0;
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;
  assign total = total_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_seq_ones_counter.sv
// Bench for seq_ones_counter: runs a table of words through the default
// build (CHUNK=4) and through a CHUNK=WIDTH build that shares its inputs,
// then follows with hand-written handshake, reset and clear sequences.
module tb_seq_ones_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic        clear;
  logic [15:0] data_in;

  logic        busy,   busy16;
  logic        done,   done16;
  logic [4:0]  count,  count16;
  logic [7:0]  total,  total16;
  logic        sat,    sat16;

  int tests = 0;
  int fails = 0;

  seq_ones_counter #(.WIDTH(16), .CHUNK(4), .ACC_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .clear(clear),
    .data_in(data_in), .busy(busy), .done(done), .count(count),
    .total(total), .sat(sat)
  );

  seq_ones_counter #(.WIDTH(16), .CHUNK(16), .ACC_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .clear(clear),
    .data_in(data_in), .busy(busy16), .done(done16), .count(count16),
    .total(total16), .sat(sat16)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] data;
    logic        mode;
    logic        clr;
    int          ec;
    int          et;
    int          es;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive a start and wait (bounded) for done on the main build. The
  // CHUNK=16 build sees the same word and is checked on the side.
  task automatic do_word(input logic [15:0] d, input logic m, input int ec,
                         input int et, input int es, input string nm);
    int  busy_n;
    int  lat;
    int  lat16;
    bit  seen;
    bit  seen16;
    @(negedge clk);
    start = 1'b1; data_in = d; mode = m;
    @(negedge clk);
    // changes after acceptance must be ignored
    start = 1'b0; data_in = ~d; mode = ~m;
    busy_n = 0; lat = -1; lat16 = -1; seen = 0; seen16 = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (busy) busy_n++;
      if (done16 && !seen16) begin
        seen16 = 1;
        lat16  = k;
        check({nm, " count16"}, int'(count16), ec);
      end
      if (done) begin
        seen = 1;
        lat  = k;
        check({nm, " count"}, int'(count), ec);
        check({nm, " total"}, int'(total), et);
        check({nm, " sat"},   int'(sat),   es);
      end else begin
        @(negedge clk);
      end
    end
    check({nm, " latency"},   lat,    4);
    check({nm, " busy_cyc"},  busy_n, 5);
    check({nm, " latency16"}, lat16,  1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int  acc;
    int  dones;
    int  cnt;
    bit  seen;

    rst = 1'b1; start = 1'b0; mode = 1'b0; clear = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy",  int'(busy),  0);
    check("reset done",  int'(done),  0);
    check("reset count", int'(count), 0);
    check("reset total", int'(total), 0);
    check("reset sat",   int'(sat),   0);
    check("reset busy16", int'(busy16), 0);

    // vector table
    vecs.push_back('{16'h0000, 1'b0, 1'b0, 0,  0,  0});
    vecs.push_back('{16'hFFFF, 1'b0, 1'b0, 16, 16, 0});
    vecs.push_back('{16'h1234, 1'b0, 1'b0, 5,  5,  0});
    vecs.push_back('{16'h8001, 1'b0, 1'b0, 2,  2,  0});
    vecs.push_back('{16'h00FF, 1'b1, 1'b1, 8,  8,  0});
    vecs.push_back('{16'h0F0F, 1'b1, 1'b0, 8,  16, 0});
    acc = 16;
    for (int i = 0; i < 16; i++) begin
      acc = acc + 16;
      vecs.push_back('{16'hFFFF, 1'b1, 1'b0, 16,
                       (acc > 255) ? 255 : acc, (acc > 255) ? 1 : 0});
    end
    vecs.push_back('{16'h0001, 1'b0, 1'b0, 1, 1, 1});

    foreach (vecs[i]) begin
      if (vecs[i].clr) pulse_clear();
      do_word(vecs[i].data, vecs[i].mode, vecs[i].ec, vecs[i].et,
              vecs[i].es, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    check("hold done",  int'(done),  0);
    check("hold count", int'(count), 1);
    check("hold total", int'(total), 1);
    check("hold sat",   int'(sat),   1);

    // start while in RUN is ignored
    @(negedge clk);
    start = 1'b1; data_in = 16'hA5A5; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    dones = 0; cnt = -1;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        dones++;
        cnt = int'(count);
      end
      if (k == 1) begin
        data_in = 16'hFFFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("run start dones", dones, 1);
    check("run start count", cnt,   8);

    // start in the DONE cycle is ignored, the next cycle is accepted
    start = 1'b1; data_in = 16'h000F; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    check("done seen 000F", int'(seen),  1);
    check("count 000F",     int'(count), 4);
    start = 1'b1; data_in = 16'hFFFF;
    @(negedge clk);
    check("done start ignored", int'(busy), 0);
    data_in = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    check("next start accepted", int'(busy), 1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    check("done seen 0003", int'(seen),  1);
    check("count 0003",     int'(count), 2);

    // reset in the middle of RUN aborts the word
    @(negedge clk);
    start = 1'b1; data_in = 16'h00FF; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy",  int'(busy),  0);
    check("midrst count", int'(count), 0);
    check("midrst total", int'(total), 0);
    check("midrst sat",   int'(sat),   0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("midrst no done", dones, 0);

    // clear on the edge that would update total
    for (int i = 0; i < 12; i++) begin
      do_word(16'hFFFF, 1'b1, 16, 16 * (i + 1), 0, $sformatf("acc%0d", i));
    end
    do_word(16'h00FF, 1'b1, 8, 200, 0, "acc200");
    @(negedge clk);
    start = 1'b1; data_in = 16'h0F0F; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) clear = 1'b1;
      @(negedge clk);
    end
    clear = 1'b0;
    check("clr edge done",  int'(done),  1);
    check("clr edge count", int'(count), 8);
    check("clr edge total", int'(total), 0);
    check("clr edge sat",   int'(sat),   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_ones_counter.md
Name: seq_ones_counter

Overview:
Parametrised, sequential successor to the 3-input combinational ones counter (OC). It counts the 1 bits in a WIDTH-bit word, processing CHUNK bits per clock under a start/busy/done handshake. It also provides an optional saturating accumulator that sums counts across several words. It sits between a word source and a controller that needs population counts, either per word or over a block of words.

Parameters:
WIDTH, 16, input word width; must be ≥ 1.
CHUNK, 4, bits counted per RUN cycle; must divide WIDTH; N = WIDTH/CHUNK.
ACC_W, 8, accumulator width; must be ≥ CW, where CW = $clog2(WIDTH+1).

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to count data_in; sampled only in IDLE.
mode  input  1  sampled with start: 0 = single word, 1 = accumulate.
clear  input  1  synchronous clear of total and sat.
data_in  input  WIDTH  word to count; captured when start is accepted.
busy  output  1  high while state != IDLE.
done  output  1  one-cycle pulse; count/total valid in that cycle.
count  output  CW  ones in the last completed word; held until next completion.
total  output  ACC_W  loaded or accumulated count.
sat  output  1  sticky flag; set when the accumulator clipped.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, busy=0, done=0, count=0, total=0, sat=0, internal shift register, partial sum and index all 0. An in-flight word is aborted; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch data_in into the shift register and latch mode.
  - Set partial=0 and idx=0, then go to RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - partial += popcount(shift[CHUNK-1:0]).
  - Shift the register right by CHUNK and increment idx.
  - On the cycle where idx == N-1, the same edge also does: count <= partial + popcount(chunk), then go to DONE.
- Latency: start sampled at edge E0 → done=1 in the cycle after edge E0+N. With the defaults that is 4 cycles; with CHUNK=WIDTH it is 1 cycle.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. busy falls with done. A new start is accepted in the cycle after done.
- start while busy (RUN or DONE) is ignored and not queued. data_in and mode changes after acceptance have no effect.
- total update happens on the edge entering DONE, using the new count value c:
  - mode=0: total <= zero-extended c; sat unchanged.
  - mode=1: if total + c > 2^ACC_W - 1, then total <= 2^ACC_W - 1 and sat <= 1; otherwise total <= total + c. Compute the sum at ACC_W+1 bits.
- clear=1: total <= 0 and sat <= 0 in any state. It does not affect the FSM, count or done.
  - clear coinciding with the total-update edge: clear wins, so total=0 and sat=0.
- rst has priority over clear and over all other inputs.
- Arithmetic: partial and count are CW bits wide and cannot overflow because the maximum is WIDTH. Popcount is purely combinational within the cycle.

Test Plan:
1. Reset, then start with data_in=16'h0000, mode=0 → busy for 5 cycles, done 4 cycles after the start edge, count=0, total=0, sat=0.
2. start with 16'hFFFF, mode=0 → count=16, total=16. Repeat with the CHUNK=16 override → done 1 cycle after the start edge, count=16.
3. Accumulate: clear, then 16'h00FF (mode=1) → total=8. Then 16'h0F0F (mode=1) → total=16. Then 16 words of 16'hFFFF → total=255 and sat=1 on the final word, both held afterwards. Then a mode=0 word 16'h0001 → total=1, sat=1 (sat stays set).
4. Handshake: start with 16'hA5A5. On RUN cycle 2, set data_in=16'hFFFF and pulse start → exactly one done, count=8. A start in the DONE cycle is ignored; a start the next cycle is accepted.
5. Mid-operation reset: assert rst on RUN cycle 2 → busy=0 the next cycle, no done pulse, count=0, total=0.
6. clear asserted on the edge entering DONE with mode=1 and total=200 → done=1, count correct, total=0, sat=0.
